tmds_encoder: RTL and testbench

- Per-lane DVI/HDMI TMDS 8b/10b encoder in the `clk_par` (pixel) domain.
- Converts pixel data plus control bits into 10-bit DC-balanced symbols.
- Its `q` output drives the `d` input of one `fpga_oser10` serializer per lane, so `q[0]` is the first bit on the wire.
- Tracks running disparity across active video. During blanking it emits the four control symbols. Optionally it emits TERC4 data-island symbols.

---
 rtl/tmds_encoder.sv | 162 ++++++++++++++++
 tb/tb_tmds_encoder.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/tmds_encoder.sv
// rtl/tmds_encoder.sv - per-lane DVI/HDMI TMDS 8b/10b encoder, two-stage pipeline
//
// Ports:
//   clk_par  in   1  pixel clock, all logic on rising edge
//   arst_n   in   1  asynchronous active-low reset
//   de       in   1  data enable (1 = active video)
//   data     in   8  pixel component, used when de=1
//   ctrl     in   2  {C1,C0} control bits, used during blanking
//   isl      in   1  data-island select (only with TMDS_TERC4_EN)
//   aux      in   4  TERC4 nibble (only with TMDS_TERC4_EN)
//   q        out 10  encoded symbol, q[0] transmitted first
//
// Optional feature macro: TMDS_TERC4_EN enables TERC4 data-island symbols.

module tmds_encoder (
    input  logic       clk_par,
    input  logic       arst_n,
    input  logic       de,
    input  logic [7:0] data,
    input  logic [1:0] ctrl,
    input  logic       isl,
    input  logic [3:0] aux,
    output logic [9:0] q
);

    localparam logic [9:0] CTRL_00 = 10'b1101010100;
    localparam logic [9:0] CTRL_01 = 10'b0010101011;
    localparam logic [9:0] CTRL_10 = 10'b0101010100;
    localparam logic [9:0] CTRL_11 = 10'b1010101011;

    // Stage 1: transition minimisation
    logic [3:0] n1_data;
    logic [3:0] n1_qm;
    logic       use_xnor;
    logic [8:0] qm;

    always_comb begin
        n1_data = '0;
        for (int i = 0; i < 8; i++) begin
            n1_data = n1_data + {3'b000, data[i]};
        end
        use_xnor = (n1_data > 4'd4) || ((n1_data == 4'd4) && !data[0]);
        qm       = '0;
        qm[0]    = data[0];
        for (int i = 1; i < 8; i++) begin
            qm[i] = use_xnor ? ~(qm[i-1] ^ data[i]) : (qm[i-1] ^ data[i]);
        end
        qm[8] = ~use_xnor;
        n1_qm = '0;
        for (int i = 0; i < 8; i++) begin
            n1_qm = n1_qm + {3'b000, qm[i]};
        end
    end

    logic [8:0] s1_qm;
    logic [3:0] s1_n1m;
    logic       s1_de;
    logic [1:0] s1_ctrl;
`ifdef TMDS_TERC4_EN
    logic       s1_isl;
    logic [3:0] s1_aux;
`else
    // Island inputs are deliberately dropped in the DVI-only build.
    logic       unused_island;
    assign unused_island = ^{isl, aux};
`endif

    always_ff @(posedge clk_par or negedge arst_n) begin
        if (!arst_n) begin
            s1_qm   <= '0;
            s1_n1m  <= '0;
            s1_de   <= 1'b0;
            s1_ctrl <= 2'b00;
`ifdef TMDS_TERC4_EN
            s1_isl  <= 1'b0;
            s1_aux  <= '0;
`endif
        end else begin
            s1_qm   <= qm;
            s1_n1m  <= n1_qm;
            s1_de   <= de;
            s1_ctrl <= ctrl;
`ifdef TMDS_TERC4_EN
            s1_isl  <= isl;
            s1_aux  <= aux;
`endif
        end
    end

`ifdef TMDS_TERC4_EN
    function automatic logic [9:0] terc4(input logic [3:0] nib);
        case (nib)
            4'h0: terc4 = 10'b1010011100;
            4'h1: terc4 = 10'b1001100011;
            4'h2: terc4 = 10'b1011100100;
            4'h3: terc4 = 10'b1011100010;
            4'h4: terc4 = 10'b0101110001;
            4'h5: terc4 = 10'b0100011110;
            4'h6: terc4 = 10'b0110001110;
            4'h7: terc4 = 10'b0100111100;
            4'h8: terc4 = 10'b1011001100;
            4'h9: terc4 = 10'b0100111001;
            4'hA: terc4 = 10'b0110011100;
            4'hB: terc4 = 10'b1011000110;
            4'hC: terc4 = 10'b1010001110;
            4'hD: terc4 = 10'b1001110001;
            4'hE: terc4 = 10'b0101100011;
            default: terc4 = 10'b1011000011;
        endcase
    endfunction
`endif

    // Stage 2: DC balancing. cnt is two's complement; arithmetic is done
    // modulo 32, which is exact because |cnt| stays within 10.
    logic [4:0] cnt;
    logic [4:0] cnt_nx;
    logic [4:0] bal;      // n1m - n0m = 2*n1m - 8
    logic [9:0] q_nx;
    logic       qm8;

    always_comb begin
        qm8    = s1_qm[8];
        bal    = {s1_n1m, 1'b0} - 5'd8;
        cnt_nx = 5'd0;
        q_nx   = CTRL_00;
        if (s1_de) begin
            if ((cnt == 5'd0) || (s1_n1m == 4'd4)) begin
                q_nx   = {~qm8, qm8, qm8 ? s1_qm[7:0] : ~s1_qm[7:0]};
                cnt_nx = qm8 ? (cnt + bal) : (cnt - bal);
            end else if ((!cnt[4] && (s1_n1m > 4'd4)) || (cnt[4] && (s1_n1m < 4'd4))) begin
                q_nx   = {1'b1, qm8, ~s1_qm[7:0]};
                cnt_nx = cnt + {3'b000, qm8, 1'b0} - bal;
            end else begin
                q_nx   = {1'b0, qm8, s1_qm[7:0]};
                cnt_nx = cnt + bal - {3'b000, ~qm8, 1'b0};
            end
        end else begin
            case (s1_ctrl)
                2'b00:   q_nx = CTRL_00;
                2'b01:   q_nx = CTRL_01;
                2'b10:   q_nx = CTRL_10;
                default: q_nx = CTRL_11;
            endcase
`ifdef TMDS_TERC4_EN
            if (s1_isl) begin
                q_nx = terc4(s1_aux);
            end
`endif
        end
    end

    always_ff @(posedge clk_par or negedge arst_n) begin
        if (!arst_n) begin
            cnt <= 5'd0;
            q   <= CTRL_00;
        end else begin
            cnt <= cnt_nx;
            q   <= q_nx;
        end
    end

endmodule

// File: tb/tb_tmds_encoder.sv
// tb/tb_tmds_encoder.sv - randomized self-checking bench for tmds_encoder
module tb_tmds_encoder;

    logic       clk_par = 1'b0;
    logic       arst_n;
    logic       de;
    logic [7:0] data;
    logic [1:0] ctrl;
    logic       isl;
    logic [3:0] aux;
    logic [9:0] q;

    always #5 clk_par = ~clk_par;

    tmds_encoder dut (
        .clk_par (clk_par),
        .arst_n  (arst_n),
        .de      (de),
        .data    (data),
        .ctrl    (ctrl),
        .isl     (isl),
        .aux     (aux),
        .q       (q)
    );

    localparam logic [9:0] RST_SYM = 10'b1101010100;
    localparam logic [9:0] CTRL_SYM [4] = '{10'b1101010100, 10'b0010101011,
                                            10'b0101010100, 10'b1010101011};
    localparam logic [9:0] TERC_SYM [16] = '{
        10'b1010011100, 10'b1001100011, 10'b1011100100, 10'b1011100010,
        10'b0101110001, 10'b0100011110, 10'b0110001110, 10'b0100111100,
        10'b1011001100, 10'b0100111001, 10'b0110011100, 10'b1011000110,
        10'b1010001110, 10'b1001110001, 10'b0101100011, 10'b1011000011};

    typedef struct {
        logic [9:0] q;
        int         cnt;
    } exp_t;

    exp_t expq[$];
    int   checks = 0;
    int   errors = 0;
    int   m_cnt  = 0;

    task automatic check(input string tag, input logic [9:0] got, input logic [9:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%b exp=%b", tag, got, exp);
        end
    endtask

    // Reference: transition-minimise, then pick the polarity that pulls the
    // running disparity toward zero; disparity grows by (ones - zeros) of the
    // emitted 10-bit symbol.
    function automatic logic [9:0] model(input logic d_de, input logic [7:0] d,
                                         input logic [1:0] c, input logic il,
                                         input logic [3:0] a);
        logic [8:0] qm;
        logic [9:0] sym;
        int         n1;
        int         ones;
        logic       xn;
        if (!d_de) begin
            m_cnt = 0;
            sym   = CTRL_SYM[c];
`ifdef TMDS_TERC4_EN
            if (il) sym = TERC_SYM[a];
`else
            if (il && (a == 4'hF) && 1'b0) sym = '0;
`endif
            return sym;
        end
        n1    = $countones(d);
        xn    = (n1 > 4) || (n1 == 4 && d[0] == 1'b0);
        qm    = '0;
        qm[0] = d[0];
        for (int i = 1; i < 8; i++) qm[i] = xn ? ~(qm[i-1] ^ d[i]) : (qm[i-1] ^ d[i]);
        qm[8] = !xn;
        ones  = $countones(qm[7:0]);
        if (m_cnt == 0 || ones == 4)
            sym = qm[8] ? {2'b01, qm[7:0]} : {2'b10, ~qm[7:0]};
        else if ((m_cnt > 0) == (ones > 4))
            sym = {1'b1, qm[8], ~qm[7:0]};
        else
            sym = {1'b0, qm[8], qm[7:0]};
        m_cnt = m_cnt + 2 * $countones(sym) - 10;
        return sym;
    endfunction

    task automatic prefill();
        exp_t e;
        e.q   = RST_SYM;
        e.cnt = 0;
        expq.push_back(e);
        expq.push_back(e);
    endtask

    // lit[10] set: the symbol is checked against the literal in lit[9:0].
    task automatic step(input string tag, input logic d_de, input logic [7:0] d,
                        input logic [1:0] c, input logic il, input logic [3:0] a,
                        input logic [10:0] lit);
        exp_t e;
        exp_t n;
        @(posedge clk_par);
        #1;
        if (expq.size() >= 2) begin
            e = expq.pop_front();
            check({tag, "_q"}, q, e.q);
            check({tag, "_cnt"}, 10'($signed(dut.cnt)), 10'(e.cnt));
        end
        de   = d_de;
        data = d;
        ctrl = c;
        isl  = il;
        aux  = a;
        n.q  = model(d_de, d, c, il, a);
        if (lit[10]) n.q = lit[9:0];
        n.cnt = m_cnt;
        expq.push_back(n);
    endtask

    task automatic reset_mid();
        #2;
        arst_n = 1'b0;
        #1;
        check("midrst_q", q, RST_SYM);
        check("midrst_cnt", 10'($signed(dut.cnt)), 10'd0);
        expq.delete();
        m_cnt = 0;
        de    = 1'b0;
        data  = '0;
        ctrl  = 2'b00;
        isl   = 1'b0;
        aux   = '0;
        prefill();
        @(negedge clk_par);
        arst_n = 1'b1;
    endtask

    initial begin
        logic [9:0] terc_exp;
        logic       r_de;
        arst_n = 1'b0;
        de     = 1'b0;
        data   = '0;
        ctrl   = 2'b00;
        isl    = 1'b0;
        aux    = '0;
        #12;
        check("rst_q", q, RST_SYM);
        check("rst_cnt", 10'($signed(dut.cnt)), 10'd0);
        prefill();
        @(negedge clk_par);
        arst_n = 1'b1;

        for (int i = 0; i < 4; i++)
            step("ctrl", 1'b0, 8'h00, 2'(i), 1'b0, 4'h0, {1'b1, CTRL_SYM[i]});

        for (int i = 0; i < 8; i++)
            step("px00", 1'b1, 8'h00, 2'b00, 1'b0, 4'h0, 11'd0);

        step("bal_a", 1'b1, 8'h01, 2'b00, 1'b0, 4'h0, 11'd0);
        step("bal_b", 1'b1, 8'h01, 2'b00, 1'b0, 4'h0, 11'd0);
        step("blank", 1'b0, 8'h00, 2'b10, 1'b0, 4'h0, {1'b1, CTRL_SYM[2]});
        step("pxff", 1'b1, 8'hFF, 2'b00, 1'b0, 4'h0, 11'd0);
        step("pxff", 1'b1, 8'hFF, 2'b00, 1'b0, 4'h0, 11'd0);

        for (int i = 0; i < 16; i++) begin
`ifdef TMDS_TERC4_EN
            terc_exp = TERC_SYM[i];
`else
            terc_exp = CTRL_SYM[0];
`endif
            step("terc", 1'b0, 8'h00, 2'b00, 1'b1, 4'(i), {1'b1, terc_exp});
        end

        for (int i = 0; i < 10000; i++) begin
            r_de = ($urandom_range(0, 7) != 0);
            step("rnd", r_de, 8'($urandom), 2'($urandom), 1'($urandom_range(0, 3) == 0),
                 4'($urandom), 11'd0);
            if (i == 5000) begin
                step("pre_rst", 1'b1, 8'hA5, 2'b00, 1'b0, 4'h0, 11'd0);
                reset_mid();
            end
        end

        for (int i = 0; i < 3; i++)
            step("drain", 1'b0, 8'h00, 2'b00, 1'b0, 4'h0, {1'b1, CTRL_SYM[0]});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
